tf_addr_gen: RTL

//  Twiddle-factor address sequencer feeding tf_rom_wrapper.addr_tfsr.

---
 rtl/tf_addr_gen_pkg.sv | 54 +++++
 rtl/tf_addr_gen_if.sv | 50 +++++
 rtl/tf_valid_dly.sv | 52 +++++
 rtl/tf_addr_gen.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/tf_addr_gen_pkg.sv
// ---------------------------------------------------------------------------
// tf_addr_gen_pkg
//   Shared definitions for the twiddle-factor address sequencer and any other
//   twiddle-ROM consumer: FSM encodings, address width and the offset/address
//   functions, so every user computes identical ROM addresses.
// ---------------------------------------------------------------------------
package tf_addr_gen_pkg;

  localparam int TF_ADDR_WIDTH = 11;
  localparam int STAGE_WIDTH   = 4;
  localparam int CNT_ARG_WIDTH = 16;

  typedef enum logic [1:0] {
    TFG_IDLE  = 2'd0,
    TFG_RUN   = 2'd1,
    TFG_DRAIN = 2'd2,
    TFG_DONE  = 2'd3
  } tfg_state_e;

  // First ROM word of stage s. Stage s (s <= log_cyc) holds 2^s distinct
  // twiddles; later stages all hold 2^log_cyc.
  function automatic int unsigned tf_offset(input logic [STAGE_WIDTH-1:0] s,
                                            input int unsigned log_cyc);
    int unsigned s_i;
    int unsigned off;
    s_i = 32'(s);
    if (s_i <= log_cyc) begin
      off = (32'd1 << s_i) - 32'd1;
    end else begin
      off = ((32'd1 << log_cyc) - 32'd1) + ((s_i - log_cyc) << log_cyc);
    end
    return off;
  endfunction

  // Twiddle address for stage s at in-stage cycle cnt. Early stages repeat
  // each twiddle 2^(log_cyc - s) times, hence the right shift of cnt.
  function automatic logic [TF_ADDR_WIDTH-1:0] tf_addr_calc(
      input logic [STAGE_WIDTH-1:0]   s,
      input logic [CNT_ARG_WIDTH-1:0] cnt,
      input int unsigned              log_cyc);
    int unsigned s_i;
    int unsigned sh;
    int unsigned a;
    s_i = 32'(s);
    if (s_i <= log_cyc) begin
      sh = log_cyc - s_i;
    end else begin
      sh = 32'd0;
    end
    a = tf_offset(s, log_cyc) + (32'(cnt) >> sh);
    return a[TF_ADDR_WIDTH-1:0];
  endfunction

endpackage

// File: rtl/tf_addr_gen_if.sv
// ---------------------------------------------------------------------------
// tf_addr_gen_if
//   Control/status bundle between the NTT/INTT controller (master) and the
//   twiddle address sequencer (slave).
//   start      controller -> sequencer  1-cycle run request
//   en         controller -> sequencer  advance enable (downstream ready)
//   addr_tfsr  sequencer -> ROM          twiddle ROM address
//   addr_valid sequencer -> consumers    addr_tfsr is a live request
//   stage      sequencer -> consumers    stage of the presented address
//   tf_valid   sequencer -> butterflies  ROM data valid this cycle
//   stage_done sequencer -> controller   pulse with last address of a stage
//   busy/done  sequencer -> controller   run status / completion pulse
// ---------------------------------------------------------------------------
interface tf_addr_gen_if;

  logic                                        start;
  logic                                        en;
  logic [tf_addr_gen_pkg::TF_ADDR_WIDTH-1:0]   addr_tfsr;
  logic                                        addr_valid;
  logic [tf_addr_gen_pkg::STAGE_WIDTH-1:0]     stage;
  logic                                        tf_valid;
  logic                                        stage_done;
  logic                                        busy;
  logic                                        done;

  modport master (
    output start,
    output en,
    input  addr_tfsr,
    input  addr_valid,
    input  stage,
    input  tf_valid,
    input  stage_done,
    input  busy,
    input  done
  );

  modport slave (
    input  start,
    input  en,
    output addr_tfsr,
    output addr_valid,
    output stage,
    output tf_valid,
    output stage_done,
    output busy,
    output done
  );

endinterface

// File: rtl/tf_valid_dly.sv
// ---------------------------------------------------------------------------
// tf_valid_dly
//   1-bit shift register of DEPTH stages that realigns the address-valid flag
//   with the twiddle ROM output. It shifts every cycle because the ROM itself
//   is free-running.
//   clk, rst_n  clock, asynchronous active-low reset
//   din_i       flag entering the pipe
//   dout_o      flag leaving the pipe (registered)
//   pending_o   some set bit will still be in the pipe after the next shift
// ---------------------------------------------------------------------------
module tf_valid_dly #(
  parameter int DEPTH = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic din_i,
  output logic dout_o,
  output logic pending_o
);

  logic [DEPTH-1:0] pipe_q;
  logic [DEPTH-1:0] pipe_d;

  generate
    if (DEPTH == 1) begin : g_single
      // Single stage: the pipe simply captures the input.
      always_comb begin
        pipe_d = din_i;
      end
    end else begin : g_multi
      // Multi stage: shift towards the MSB, new flag enters at bit 0.
      always_comb begin
        pipe_d = {pipe_q[DEPTH-2:0], din_i};
      end
    end
  endgenerate

  // Pipe register, cleared by reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pipe_q <= {DEPTH{1'b0}};
    end else begin
      pipe_q <= pipe_d;
    end
  end

  assign dout_o    = pipe_q[DEPTH-1];
  // Looking at the next pipe value lets the owner finish on the very edge
  // the last valid flag leaves.
  assign pending_o = |pipe_d;

endmodule

// File: rtl/tf_addr_gen.sv
// ---------------------------------------------------------------------------
// tf_addr_gen
//   Twiddle-factor address sequencer. Walks all LOG_N stages (ascending for
//   NTT, descending for INTT), emitting one ROM address per enabled cycle,
//   and raises tf_valid once the ROM read latency has elapsed.
//   clk    clock
//   rst_n  asynchronous active-low reset; aborts a run without a done pulse
//   bus    tf_addr_gen_if.slave: start/en in; addr_tfsr, addr_valid, stage,
//          tf_valid, stage_done, busy, done out (all registered)
// ---------------------------------------------------------------------------
module tf_addr_gen
  import tf_addr_gen_pkg::*;
#(
  parameter int NTT_INTT_CASE     = 0,
  parameter int LOG_N             = 12,
  parameter int LOG_CYC           = 9,
  parameter int COMMON_BRAM_DELAY = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  tf_addr_gen_if.slave bus
);

  localparam logic [STAGE_WIDTH-1:0] FIRST_STAGE =
      (NTT_INTT_CASE == 0) ? 4'd0 : 4'(LOG_N - 1);
  localparam logic [STAGE_WIDTH-1:0] LAST_STAGE =
      (NTT_INTT_CASE == 0) ? 4'(LOG_N - 1) : 4'd0;
  localparam logic [LOG_CYC-1:0] CNT_MAX = {LOG_CYC{1'b1}};
  localparam logic [LOG_CYC-1:0] CNT_ONE = LOG_CYC'(1);

  tfg_state_e               state_q, state_d;
  logic [LOG_CYC-1:0]       cnt_q, cnt_d;
  logic [STAGE_WIDTH-1:0]   stage_q, stage_d;       // stage of the next address
  logic [STAGE_WIDTH-1:0]   stage_o_q, stage_o_d;   // stage of the presented address
  logic [TF_ADDR_WIDTH-1:0] addr_q, addr_d;
  logic                     addr_valid_q, addr_valid_d;
  logic                     stage_done_q, stage_done_d;
  logic                     busy_q, busy_d;
  logic                     done_q, done_d;

  logic                     last_cnt_s;
  logic                     last_stage_s;
  logic                     pending_s;
  logic                     tf_valid_s;
  logic [STAGE_WIDTH-1:0]   stage_step_s;

  assign last_cnt_s   = (cnt_q == CNT_MAX);
  assign last_stage_s = (stage_q == LAST_STAGE);
  assign stage_step_s = (NTT_INTT_CASE == 0) ? (stage_q + 4'd1) : (stage_q - 4'd1);

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= TFG_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      TFG_IDLE: begin
        if (bus.start) begin
          state_d = TFG_RUN;
        end else begin
          state_d = TFG_IDLE;
        end
      end
      TFG_RUN: begin
        if (bus.en && last_cnt_s && last_stage_s) begin
          state_d = TFG_DRAIN;
        end else begin
          state_d = TFG_RUN;
        end
      end
      TFG_DRAIN: begin
        if (pending_s) begin
          state_d = TFG_DRAIN;
        end else begin
          state_d = TFG_DONE;
        end
      end
      TFG_DONE: begin
        state_d = TFG_IDLE;
      end
      default: begin
        state_d = TFG_IDLE;
      end
    endcase
  end

  // FSM output / datapath next values. Everything holds unless the state
  // and en say otherwise; pulses default to 0.
  always_comb begin
    cnt_d        = cnt_q;
    stage_d      = stage_q;
    stage_o_d    = stage_o_q;
    addr_d       = addr_q;
    addr_valid_d = 1'b0;
    stage_done_d = 1'b0;
    busy_d       = busy_q;
    done_d       = 1'b0;
    case (state_q)
      TFG_IDLE: begin
        if (bus.start) begin
          cnt_d     = {LOG_CYC{1'b0}};
          stage_d   = FIRST_STAGE;
          stage_o_d = FIRST_STAGE;
          addr_d    = tf_addr_calc(FIRST_STAGE, 16'd0, LOG_CYC);
          busy_d    = 1'b1;
        end else begin
          busy_d    = 1'b0;
        end
      end
      TFG_RUN: begin
        if (bus.en) begin
          addr_valid_d = 1'b1;
          addr_d       = tf_addr_calc(stage_q, 16'(cnt_q), LOG_CYC);
          stage_o_d    = stage_q;
          cnt_d        = cnt_q + CNT_ONE;   // wraps to 0 after CNT_MAX
          if (last_cnt_s) begin
            stage_done_d = 1'b1;
            // The final stage index is kept rather than stepping past it.
            if (!last_stage_s) begin
              stage_d = stage_step_s;
            end else begin
              stage_d = stage_q;
            end
          end else begin
            stage_done_d = 1'b0;
          end
        end else begin
          addr_valid_d = 1'b0;
        end
      end
      TFG_DRAIN: begin
        if (!pending_s) begin
          done_d = 1'b1;
          busy_d = 1'b0;
        end else begin
          done_d = 1'b0;
        end
      end
      TFG_DONE: begin
        busy_d = 1'b0;
      end
      default: begin
        busy_d = 1'b0;
      end
    endcase
  end

  // Datapath and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q        <= {LOG_CYC{1'b0}};
      stage_q      <= 4'd0;
      stage_o_q    <= 4'd0;
      addr_q       <= 11'd0;
      addr_valid_q <= 1'b0;
      stage_done_q <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      cnt_q        <= cnt_d;
      stage_q      <= stage_d;
      stage_o_q    <= stage_o_d;
      addr_q       <= addr_d;
      addr_valid_q <= addr_valid_d;
      stage_done_q <= stage_done_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
    end
  end

  tf_valid_dly #(
    .DEPTH (COMMON_BRAM_DELAY)
  ) u_tf_valid_dly (
    .clk       (clk),
    .rst_n     (rst_n),
    .din_i     (addr_valid_q),
    .dout_o    (tf_valid_s),
    .pending_o (pending_s)
  );

  assign bus.addr_tfsr  = addr_q;
  assign bus.addr_valid = addr_valid_q;
  assign bus.stage      = stage_o_q;
  assign bus.tf_valid   = tf_valid_s;
  assign bus.stage_done = stage_done_q;
  assign bus.busy       = busy_q;
  assign bus.done       = done_q;

endmodule
